// File: rtl/aes_result_checker_if.sv
// FIFO read ports and DUT block handshake seen by aes_result_checker.
// master = checker side, slave = generator FIFOs plus AES chip side.
interface aes_result_checker_if;
  localparam int unsigned BLK_W = 128;

  logic             data_empty;
  logic             data_require;
  logic [BLK_W-1:0] data;
  logic             result_empty;
  logic             result_require;
  logic [BLK_W-1:0] result;
  logic             dut_in_valid;
  logic [BLK_W-1:0] dut_in_data;
  logic             dut_in_ready;
  logic             dut_out_valid;
  logic [BLK_W-1:0] dut_out_data;

  modport master (
    output data_require, result_require, dut_in_valid, dut_in_data,
    input  data_empty, data, result_empty, result,
    input  dut_in_ready, dut_out_valid, dut_out_data
  );

  modport slave (
    input  data_require, result_require, dut_in_valid, dut_in_data,
    output data_empty, data, result_empty, result,
    output dut_in_ready, dut_out_valid, dut_out_data
  );
endinterface

// File: rtl/aes_result_checker.sv
// Feeds generator plaintext to the AES chip and checks its output against the golden ciphertext.
// Optional first-failure capture ports are enabled by defining AES_CHECKER_CAPTURE_EN.
module aes_result_checker #(
  parameter int unsigned CNT_W   = 32,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  work,
  input  logic                  clear,
  aes_result_checker_if.master  bus,
  output logic                  busy,
  output logic                  error,
  output logic [CNT_W-1:0]      pass_cnt,
  output logic [CNT_W-1:0]      fail_cnt,
  output logic [CNT_W-1:0]      timeout_cnt
`ifdef AES_CHECKER_CAPTURE_EN
  ,
  output logic                  cap_valid,
  output logic [127:0]          cap_pt,
  output logic [127:0]          cap_exp,
  output logic [127:0]          cap_act
`endif
);

  localparam int unsigned     BLK_W   = 128;
  localparam int unsigned     TMR_W   = 16;
  localparam logic [TMR_W-1:0] TMR_LIM = TMR_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  typedef enum logic [2:0] {
    IDLE, LD_DATA, SEND, WAIT_DUT, GET_RES, LD_RES, CMP
  } state_t;

  state_t           r_state, w_state_nxt;
  logic             w_data_require, w_result_require;
  logic             w_tmo_hit, w_match, w_clear;
  logic [TMR_W-1:0] r_timer;
  logic             r_tmo;
  logic [BLK_W-1:0] r_pt, r_act, r_exp;
  logic             r_dut_in_valid, r_busy, r_error;
  logic [CNT_W-1:0] r_pass, r_fail, r_tmo_cnt;

  // Valid output wins over the limit when both land in the same cycle.
  assign w_tmo_hit = (r_timer == TMR_LIM) && !bus.dut_out_valid;
  assign w_match   = (r_exp == r_act);
  assign w_clear   = clear && (r_state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // Pop strobes are issued from the current state so FIFO data lands in LD_DATA/LD_RES.
  always_comb begin
    w_state_nxt      = r_state;
    w_data_require   = 1'b0;
    w_result_require = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (work && !bus.data_empty) begin
          w_data_require = 1'b1;
          w_state_nxt    = LD_DATA;
        end
      end
      LD_DATA:  w_state_nxt = SEND;
      SEND:     if (bus.dut_in_ready) w_state_nxt = WAIT_DUT;
      WAIT_DUT: if (bus.dut_out_valid || w_tmo_hit) w_state_nxt = GET_RES;
      GET_RES: begin
        if (!bus.result_empty) begin
          w_result_require = 1'b1;
          w_state_nxt      = LD_RES;
        end
      end
      LD_RES:   w_state_nxt = CMP;
      CMP:      w_state_nxt = IDLE;
      default:  w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_dut_in_valid <= 1'b0;
      r_busy         <= 1'b0;
      r_timer        <= '0;
      r_tmo          <= 1'b0;
      r_pt           <= '0;
      r_act          <= '0;
      r_exp          <= '0;
      r_error        <= 1'b0;
      r_pass         <= '0;
      r_fail         <= '0;
      r_tmo_cnt      <= '0;
    end else begin
      r_dut_in_valid <= (w_state_nxt == SEND);
      r_busy         <= (w_state_nxt != IDLE);
      r_timer        <= (r_state == WAIT_DUT) ? r_timer + TMR_W'(1) : '0;
      if (r_state == LD_DATA) r_pt <= bus.data;
      if (r_state == LD_RES)  r_exp <= bus.result;
      if (r_state == WAIT_DUT) begin
        if (bus.dut_out_valid) r_act <= bus.dut_out_data;
        else if (w_tmo_hit)    r_tmo <= 1'b1;
      end
      if (w_clear) begin
        r_error   <= 1'b0;
        r_pass    <= '0;
        r_fail    <= '0;
        r_tmo_cnt <= '0;
      end else if (r_state == CMP) begin
        r_tmo <= 1'b0;
        if (r_tmo) begin
          r_error <= 1'b1;
          if (r_tmo_cnt != CNT_MAX) r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end else if (w_match) begin
          if (r_pass != CNT_MAX) r_pass <= r_pass + CNT_W'(1);
        end else begin
          r_error <= 1'b1;
          if (r_fail != CNT_MAX) r_fail <= r_fail + CNT_W'(1);
        end
      end
    end
  end

  assign bus.data_require   = w_data_require;
  assign bus.result_require = w_result_require;
  assign bus.dut_in_valid   = r_dut_in_valid;
  assign bus.dut_in_data    = r_pt;
  assign busy               = r_busy;
  assign error              = r_error;
  assign pass_cnt           = r_pass;
  assign fail_cnt           = r_fail;
  assign timeout_cnt        = r_tmo_cnt;

`ifdef AES_CHECKER_CAPTURE_EN
  logic             r_cap_valid;
  logic [BLK_W-1:0] r_cap_pt, r_cap_exp, r_cap_act;

  // Holds only the first bad vector since reset or clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cap_valid <= 1'b0;
      r_cap_pt    <= '0;
      r_cap_exp   <= '0;
      r_cap_act   <= '0;
    end else if (w_clear) begin
      r_cap_valid <= 1'b0;
      r_cap_pt    <= '0;
      r_cap_exp   <= '0;
      r_cap_act   <= '0;
    end else if ((r_state == CMP) && !r_cap_valid && (r_tmo || !w_match)) begin
      r_cap_valid <= 1'b1;
      r_cap_pt    <= r_pt;
      r_cap_exp   <= r_exp;
      r_cap_act   <= r_tmo ? '0 : r_act;
    end
  end

  assign cap_valid = r_cap_valid;
  assign cap_pt    = r_cap_pt;
  assign cap_exp   = r_cap_exp;
  assign cap_act   = r_cap_act;
`endif

endmodule

// File: tb/tb_aes_result_checker.sv
// Directed bench for aes_result_checker: FIFO and AES chip models around the DUT,
// expected vector outcomes queued at push time and scored as each vector completes.
module tb_aes_result_checker;
  localparam int unsigned CNT_W   = 3;
  localparam int unsigned TMO     = 16;
  localparam int unsigned CNT_TOP = (1 << CNT_W) - 1;
  localparam logic [127:0] PT0 = 128'h00112233_44556677_8899aabb_ccddeeff;
  localparam logic [127:0] CT0 = 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55a;

  typedef enum logic [1:0] {EXP_PASS, EXP_FAIL, EXP_TMO} outcome_t;
  typedef struct packed {
    logic         ok;
    logic [127:0] data;
  } resp_t;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             work = 1'b0;
  logic             clear = 1'b0;
  logic             busy, error;
  logic [CNT_W-1:0] pass_cnt, fail_cnt, timeout_cnt;
`ifdef AES_CHECKER_CAPTURE_EN
  logic             cap_valid;
  logic [127:0]     cap_pt, cap_exp, cap_act;
`endif

  aes_result_checker_if bus();

  aes_result_checker #(.CNT_W(CNT_W), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n), .work(work), .clear(clear), .bus(bus),
    .busy(busy), .error(error),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .timeout_cnt(timeout_cnt)
`ifdef AES_CHECKER_CAPTURE_EN
    , .cap_valid(cap_valid), .cap_pt(cap_pt), .cap_exp(cap_exp), .cap_act(cap_act)
`endif
  );

  always #5 clk = ~clk;

  logic [127:0] dq[$], rq[$];
  resp_t        resp_q[$];
  outcome_t     exp_q[$];
  int unsigned  cyc = 0, hs_cyc = 0, done_cyc = 0;
  int unsigned  dreq_cnt = 0, rreq_cnt = 0, hs_cnt = 0, viol = 0;
  int unsigned  n_checks = 0, n_fail = 0;
  int unsigned  m_pass = 0, m_fail = 0, m_tmo = 0;
  logic         m_err = 1'b0;

  // Generator FIFO read ports: flags and read data update on the clock edge.
  logic [127:0] d_pop, r_pop;
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (bus.data_require) begin
      dreq_cnt++;
      if (bus.data_empty || dq.size() == 0) viol++;
      else begin d_pop = dq.pop_front(); bus.data <= d_pop; end
    end
    if (bus.result_require) begin
      rreq_cnt++;
      if (bus.result_empty || rq.size() == 0) viol++;
      else begin r_pop = rq.pop_front(); bus.result <= r_pop; end
    end
    bus.data_empty   <= (dq.size() == 0);
    bus.result_empty <= (rq.size() == 0);
  end

  // AES chip model: answers an accepted block 10 edges later, or never.
  resp_t        cur;
  logic         pend = 1'b0;
  int unsigned  lat_cnt = 0;
  logic [127:0] pend_data = '0;
  always @(posedge clk) begin
    bus.dut_out_valid <= 1'b0;
    if (pend) begin
      if (lat_cnt == 0) begin
        bus.dut_out_valid <= 1'b1;
        bus.dut_out_data  <= pend_data;
        pend = 1'b0;
      end else lat_cnt--;
    end
    if (bus.dut_in_valid && bus.dut_in_ready) begin
      hs_cnt++;
      hs_cyc = cyc + 1;
      if (resp_q.size() != 0) begin
        cur = resp_q.pop_front();
        if (cur.ok) begin pend = 1'b1; lat_cnt = 9; pend_data = cur.data; end
      end
    end
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push_vec(input logic [127:0] pt, input logic [127:0] ct, input outcome_t o);
    resp_t r;
    r.ok   = (o != EXP_TMO);
    r.data = (o == EXP_FAIL) ? (ct ^ 128'h1) : ct;
    dq.push_back(pt);
    rq.push_back(ct);
    resp_q.push_back(r);
    exp_q.push_back(o);
  endtask

  function automatic int unsigned sat_inc(input int unsigned v);
    return (v >= CNT_TOP) ? CNT_TOP : v + 1;
  endfunction

  // Waits for one vector to finish, then scores it against the queued outcome.
  task automatic wait_vec(input string tag);
    int n = 0;
    outcome_t o;
    while (busy !== 1'b1 && n < 400) begin @(negedge clk); n++; end
    while (busy !== 1'b0 && n < 400) begin @(negedge clk); n++; end
    check({tag, "_done"}, 128'(n < 400), 128'd1);
    done_cyc = cyc;
    check({tag, "_sb_nonempty"}, 128'(exp_q.size() != 0), 128'd1);
    if (exp_q.size() == 0) return;
    o = exp_q.pop_front();
    case (o)
      EXP_PASS: m_pass = sat_inc(m_pass);
      EXP_FAIL: begin m_fail = sat_inc(m_fail); m_err = 1'b1; end
      default:  begin m_tmo = sat_inc(m_tmo); m_err = 1'b1; end
    endcase
    check({tag, "_pass_cnt"}, 128'(pass_cnt), 128'(m_pass));
    check({tag, "_fail_cnt"}, 128'(fail_cnt), 128'(m_fail));
    check({tag, "_timeout_cnt"}, 128'(timeout_cnt), 128'(m_tmo));
    check({tag, "_error"}, 128'(error), 128'(m_err));
  endtask

  task automatic pulse_clear(input string tag);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
    m_pass = 0; m_fail = 0; m_tmo = 0; m_err = 1'b0;
    check({tag, "_pass_cnt"}, 128'(pass_cnt), 128'd0);
    check({tag, "_fail_cnt"}, 128'(fail_cnt), 128'd0);
    check({tag, "_timeout_cnt"}, 128'(timeout_cnt), 128'd0);
    check({tag, "_error"}, 128'(error), 128'd0);
`ifdef AES_CHECKER_CAPTURE_EN
    check({tag, "_cap_valid"}, 128'(cap_valid), 128'd0);
`endif
  endtask

  initial begin
    int unsigned r0, h0, n;
    logic [127:0] pt, ct;
    bus.dut_in_ready = 1'b1;
    repeat (3) @(negedge clk);

    check("rst_busy", 128'(busy), 128'd0);
    check("rst_error", 128'(error), 128'd0);
    check("rst_pass_cnt", 128'(pass_cnt), 128'd0);
    check("rst_fail_cnt", 128'(fail_cnt), 128'd0);
    check("rst_timeout_cnt", 128'(timeout_cnt), 128'd0);
    check("rst_in_valid", 128'(bus.dut_in_valid), 128'd0);
    check("rst_in_data", bus.dut_in_data, 128'd0);
    check("rst_data_require", 128'(bus.data_require), 128'd0);
    check("rst_result_require", 128'(bus.result_require), 128'd0);
    rst_n = 1'b1;
    @(negedge clk);

    // Basic pass: accept edge to completion edge is 14 with a 10-edge chip
    push_vec(PT0, CT0, EXP_PASS);
    work = 1'b1;
    wait_vec("pass");
    check("pass_latency", 128'(done_cyc - hs_cyc), 128'd14);
    check("pass_busy_after", 128'(busy), 128'd0);

    push_vec(PT0, CT0, EXP_FAIL);
    wait_vec("mismatch");
`ifdef AES_CHECKER_CAPTURE_EN
    check("mis_cap_valid", 128'(cap_valid), 128'd1);
    check("mis_cap_pt", cap_pt, PT0);
    check("mis_cap_exp", cap_exp, CT0);
    check("mis_cap_act", cap_act, 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55b);
`endif

    // Timeout: 16 WAIT cycles, then GET_RES, LD_RES, CMP
    r0 = rreq_cnt;
    push_vec(128'h1, 128'h2, EXP_TMO);
    wait_vec("timeout");
    check("tmo_latency", 128'(done_cyc - hs_cyc), 128'd19);
    check("tmo_result_pops", 128'(rreq_cnt - r0), 128'd1);
`ifdef AES_CHECKER_CAPTURE_EN
    check("tmo_cap_keeps_first", cap_act, 128'h69c4e0d8_6a7b0430_d8cdb780_70b4c55b);
`endif

    h0 = hs_cnt;
    bus.dut_in_ready = 1'b0;
    pt = 128'hdeadbeef_01234567_89abcdef_cafef00d;
    push_vec(pt, CT0, EXP_PASS);
    n = 0;
    while (bus.dut_in_valid !== 1'b1 && n < 50) begin @(negedge clk); n++; end
    check("bp_valid_seen", 128'(n < 50), 128'd1);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("bp_valid_%0d", i), 128'(bus.dut_in_valid), 128'd1);
      check($sformatf("bp_data_%0d", i), bus.dut_in_data, pt);
      @(negedge clk);
    end
    bus.dut_in_ready = 1'b1;
    wait_vec("backpressure");
    check("bp_handshakes", 128'(hs_cnt - h0), 128'd1);

    // Clear in the same cycle a vector starts: clear applies, vector still runs
    work = 1'b0;
    push_vec(PT0, CT0, EXP_PASS);
    @(negedge clk);
    work = 1'b1;
    pulse_clear("clr_start");
    check("clr_start_busy", 128'(busy), 128'd1);
    wait_vec("clr_start_vec");

    work = 1'b0;
    @(negedge clk);
    pulse_clear("clr_idle");

    h0 = hs_cnt;
    for (int i = 0; i < 8; i++) begin
      ct = {$urandom, $urandom, $urandom, $urandom};
      push_vec({$urandom, $urandom, $urandom, $urandom}, ct, EXP_PASS);
    end
    work = 1'b1;
    wait_vec("stream_v1");
    wait_vec("stream_v2");
    n = 0;
    while (hs_cnt - h0 < 3 && n < 100) begin @(negedge clk); n++; end
    check("stream_v3_started", 128'(n < 100), 128'd1);
    work = 1'b0;
    wait_vec("stream_v3");
    repeat (20) @(negedge clk);
    check("stream_busy", 128'(busy), 128'd0);
    check("stream_pass_cnt", 128'(pass_cnt), 128'd3);
    check("stream_data_left", 128'(dq.size()), 128'd5);
    check("stream_result_left", 128'(rq.size()), 128'd5);
    check("pop_while_empty", 128'(viol), 128'd0);
    dq.delete(); rq.delete(); resp_q.delete(); exp_q.delete();
    repeat (2) @(negedge clk);

    // Saturation: 3 -> 6 (all-ones minus 1), then two more stick at 7
    for (int i = 0; i < 5; i++) push_vec(PT0, CT0, EXP_PASS);
    work = 1'b1;
    for (int i = 0; i < 3; i++) wait_vec($sformatf("sat_pre%0d", i));
    check("sat_pre_value", 128'(pass_cnt), 128'd6);
    wait_vec("sat_a");
    wait_vec("sat_b");
    check("sat_value", 128'(pass_cnt), 128'd7);
    work = 1'b0;
    @(negedge clk);
    pulse_clear("clr_final");
    check("final_pop_while_empty", 128'(viol), 128'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/aes_result_checker.md
Name: aes_result_checker

Overview:
- Consumer-side companion to the AES vector generator (`datagenerator`).
- Pops plaintext words from the generator's data FIFO read port and drives each one into the AES chip under test.
- Captures the chip's output, then pops the matching golden ciphertext from the generator's result FIFO read port and compares the two.
- Keeps pass/fail/timeout counters plus a sticky error flag for the verification platform.

Parameters:
- CNT_W, 32, width of pass_cnt, fail_cnt and timeout_cnt.
- TIMEOUT, 1024, max cycles to wait for dut_out_valid after the DUT accepts a block; range 1..65535.

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- work  input  1  level; high = keep checking vectors.
- clear  input  1  one-cycle pulse; zeroes counters and error (ignored in states other than IDLE).
- data_empty  input  1  data FIFO empty.
- data_require  output  1  data FIFO pop strobe.
- data  input  128  data FIFO read data.
- result_empty  input  1  result FIFO empty.
- result_require  output  1  result FIFO pop strobe.
- result  input  128  result FIFO read data.
- dut_in_valid  output  1  block valid to DUT.
- dut_in_data  output  128  plaintext to DUT.
- dut_in_ready  input  1  DUT accepts block when valid & ready.
- dut_out_valid  input  1  one-cycle strobe, DUT result present.
- dut_out_data  input  128  DUT result.
- busy  output  1  FSM not in IDLE.
- error  output  1  sticky; set on any mismatch or timeout.
- pass_cnt  output  CNT_W  matching vectors.
- fail_cnt  output  CNT_W  mismatching vectors.
- timeout_cnt  output  CNT_W  vectors abandoned on timeout.

Behaviour:
- Reset values:
  - All outputs 0; FSM in IDLE.
  - dut_in_data and capture registers 0.
- FIFO read timing:
  - Pop strobes are single-cycle pulses.
  - FIFO read data is valid the cycle after the strobe and is sampled then.
  - A strobe is asserted only when the matching empty flag is 0.
- FSM states and transitions:
  - IDLE: if work & ~data_empty, pulse data_require and go to LD_DATA.
  - LD_DATA: register data into dut_in_data; go to SEND.
  - SEND: hold dut_in_valid=1 and dut_in_data stable until dut_in_ready, then go to WAIT_DUT.
    - Handshake completes in the cycle where valid & ready are both high.
    - dut_in_valid drops the next cycle.
  - WAIT_DUT: 16-bit timer counts from 0.
    - dut_out_valid captures dut_out_data into act_reg and goes to GET_RES.
    - Timer reaching TIMEOUT-1 without dut_out_valid: also go to GET_RES with a timeout flag set.
    - dut_out_valid in the same cycle as the limit: treated as valid, not a timeout.
  - GET_RES: wait while result_empty; pulse result_require once ~result_empty, then go to LD_RES.
    - Always pops, even on timeout, so the two FIFOs stay aligned.
  - LD_RES: register result into exp_reg; go to CMP.
  - CMP (1 cycle), exactly one counter increments:
    - timeout flag set: timeout_cnt++, error=1.
    - else exp_reg==act_reg: pass_cnt++.
    - else: fail_cnt++, error=1.
    - Then clear the timeout flag and go to IDLE.
- Throughput: minimum 7 cycles per vector with zero DUT latency; one vector in flight.
- Stopping: work deasserted mid-vector lets the current vector complete; the FSM then parks in IDLE.
- dut_out_valid outside WAIT_DUT is ignored.
- Counters saturate at all-ones and do not wrap.
- clear in IDLE takes effect next cycle. clear arriving in the same cycle as a new vector start: clear is applied, and the vector still starts.
- Reset mid-operation aborts immediately. FIFO alignment after reset is the generator's responsibility, since it resets its FIFOs on the same rst_n.
- busy = (state != IDLE).

Optional Feature:
- Macro: AES_CHECKER_CAPTURE_EN.
- Enabled: adds outputs cap_valid (1), cap_pt (128), cap_exp (128), cap_act (128).
  - On the first fail or timeout after reset/clear, latch plaintext, exp_reg and act_reg, and set cap_valid.
  - On timeout, cap_act = 0.
  - Later failures do not overwrite the capture; clear resets cap_valid and the captured values.
- Disabled: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Basic pass: FIFOs preloaded with 1 pair.
  - Stimulus: plaintext 00112233_44556677_8899aabb_ccddeeff, expected 69c4e0d8_6a7b0430_d8cdb780_70b4c55a; DUT model echoes the expected value after 10 cycles; work=1.
  - Response: pass_cnt=1, fail_cnt=0, error=0, busy low after the vector.
- Mismatch: same as basic pass, but the DUT returns expected^1.
  - Response: fail_cnt=1, error=1; with the macro, cap_exp=69c4...c55a and cap_act=69c4...c55b.
- Timeout: TIMEOUT=16, DUT never asserts dut_out_valid.
  - Response: timeout_cnt=1 at ~16 cycles after the handshake; exactly 1 result_require pulse; error=1.
- Backpressure: dut_in_ready low for 5 cycles.
  - Response: dut_in_valid stays high and dut_in_data stable throughout; exactly one handshake.
- Stream and stop: 8 matching pairs; work dropped during vector 3.
  - Response: pass_cnt=3, busy=0; 5 entries remain in each FIFO; no pop strobe while an empty flag is 1.
- Clear and saturation:
  - Force pass_cnt to all-ones minus 1 and run 2 vectors: pass_cnt = all-ones.
  - Pulse clear in IDLE: all counters 0 and error 0 next cycle.
